// File: rtl/lut_table_serializer.sv
// Serial loader for a shift-register LUT: latches a table image and shifts it
// out MSB-first on sdo/sclk/cs_n, with each sclk phase lasting CLK_DIV cycles.
module lut_table_serializer #(
  parameter int TABLE_BITS = 64,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [TABLE_BITS-1:0] table_in,
  output logic                  sdo,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(TABLE_BITS);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(TABLE_BITS - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FINISH} state_t;

  state_t                state;
  logic [TABLE_BITS-1:0] shadow;
  logic [CW-1:0]         bit_cnt;
  logic [PW-1:0]         phase;
  logic                  phase_end;

  assign phase_end = (phase == LAST_PHASE);

  // sdo only moves on the HIGH->LOW transition, so it is stable around every sclk rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shadow  <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      sdo     <= 1'b0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cs_n  <= 1'b1;
          sclk  <= 1'b0;
          sdo   <= 1'b0;
          phase <= '0;
          if (start) begin
            shadow  <= table_in;
            cs_n    <= 1'b0;
            sdo     <= table_in[TABLE_BITS-1];
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            phase <= '0;
            sclk  <= 1'b1;
            state <= HIGH;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            phase <= '0;
            sclk  <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state <= FINISH;
            end else begin
              shadow  <= {shadow[TABLE_BITS-2:0], 1'b0};
              sdo     <= shadow[TABLE_BITS-2];
              bit_cnt <= bit_cnt + 1'b1;
              state   <= LOW;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        FINISH: begin
          if (phase_end) begin
            phase <= '0;
            cs_n  <= 1'b1;
            sdo   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_table_serializer.sv
// Directed bench for lut_table_serializer: three instances with CLK_DIV = 1, 2, 3
// (index d uses CLK_DIV = d+1), checked cycle by cycle against the frame timing formulas.
module tb_lut_table_serializer;

  localparam int TB = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    rst_v;
  logic [2:0]    start_v;
  logic [TB-1:0] tbl_v [3];
  wire  [2:0]    sdo_v, sclk_v, cs_n_v, busy_v, done_v;

  int nvec = 0;
  int nmis = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lut_table_serializer #(.TABLE_BITS(TB), .CLK_DIV(g + 1)) dut (
      .clk      (clk),
      .rst_n    (rst_v[g]),
      .start    (start_v[g]),
      .table_in (tbl_v[g]),
      .sdo      (sdo_v[g]),
      .sclk     (sclk_v[g]),
      .cs_n     (cs_n_v[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g])
    );
  end

  // Starts a frame at a negedge and follows it until the done cycle; the receiver
  // is modelled by shifting sdo in on every observed sclk rise while cs_n is low.
  task automatic run_frame(input int d, input logic [TB-1:0] tbl, input bit hold,
                           input int ign_t, input logic [TB-1:0] ign_tbl, input string tag,
                           output logic [TB-1:0] rx, output logic first_bit,
                           output logic last_bit, output int ones);
    int cd, len, terr, rises, bad, busy_cyc, dones, k;
    logic prev, eb, ec, ed, es, esdo;
    cd = d + 1;
    len = (2 * TB + 1) * cd;
    terr = 0; rises = 0; bad = 0; busy_cyc = 0; dones = 0; ones = 0;
    rx = '0; first_bit = 1'b0; last_bit = 1'b0; prev = 1'b0;
    start_v[d] = 1'b1;
    tbl_v[d] = tbl;
    @(posedge clk);
    for (int t = 0; t <= len; t++) begin
      @(negedge clk);
      if (t == 0 && !hold) start_v[d] = 1'b0;
      if (t < len) begin
        eb = 1'b1; ec = 1'b0; ed = 1'b0;
        es = ((t / cd) % 2 == 1) && (t < 2 * TB * cd);
        k = t / (2 * cd);
        if (k > TB - 1) k = TB - 1;
        esdo = tbl[TB-1-k];
      end else begin
        eb = 1'b0; ec = 1'b1; ed = 1'b1; es = 1'b0; esdo = sdo_v[d];
      end
      if (busy_v[d] !== eb || cs_n_v[d] !== ec || done_v[d] !== ed ||
          sclk_v[d] !== es || sdo_v[d] !== esdo) begin
        if (terr == 0)
          $display("[TB] %s: first deviation at t=%0d busy=%b cs_n=%b done=%b sclk=%b sdo=%b",
                   tag, t, busy_v[d], cs_n_v[d], done_v[d], sclk_v[d], sdo_v[d]);
        terr++;
      end
      if (sclk_v[d] === 1'b1 && prev === 1'b0) begin
        if (cs_n_v[d] !== 1'b0) bad++;
        else begin
          rx = {rx[TB-2:0], sdo_v[d]};
          if (rises == 0) first_bit = sdo_v[d];
          if (rises == TB - 1) last_bit = sdo_v[d];
          if (sdo_v[d] === 1'b1) ones++;
          rises++;
        end
      end
      prev = sclk_v[d];
      if (busy_v[d] === 1'b1) busy_cyc++;
      if (done_v[d] === 1'b1) dones++;
      if (t == ign_t) begin
        start_v[d] = 1'b1;
        tbl_v[d] = ign_tbl;
      end
      if (t == ign_t + 1) start_v[d] = 1'b0;
    end
    nvec++;
    if (terr !== 0) begin nmis++; $display("[TB] FAIL %s timing: %0d deviating cycles, wanted 0", tag, terr); end
    nvec++;
    if (rises !== TB) begin nmis++; $display("[TB] FAIL %s sclk rises: got %0d, wanted %0d", tag, rises, TB); end
    nvec++;
    if (bad !== 0) begin nmis++; $display("[TB] FAIL %s rises with cs_n high: got %0d, wanted 0", tag, bad); end
    nvec++;
    if (busy_cyc !== len) begin nmis++; $display("[TB] FAIL %s busy cycles: got %0d, wanted %0d", tag, busy_cyc, len); end
    nvec++;
    if (dones !== 1) begin nmis++; $display("[TB] FAIL %s done pulses: got %0d, wanted 1", tag, dones); end
    nvec++;
    if (rx !== tbl) begin nmis++; $display("[TB] FAIL %s received table: got %h, wanted %h", tag, rx, tbl); end
  endtask

  task automatic test_reset();
    rst_v = 3'b000;
    start_v = 3'($urandom);
    for (int i = 0; i < 3; i++) tbl_v[i] = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      nvec++;
      if ({sdo_v[d], sclk_v[d], cs_n_v[d], busy_v[d], done_v[d]} !== 5'b00100) begin
        nmis++;
        $display("[TB] FAIL reset[%0d]: sdo/sclk/cs_n/busy/done got %b%b%b%b%b, wanted 00100",
                 d, sdo_v[d], sclk_v[d], cs_n_v[d], busy_v[d], done_v[d]);
      end
    end
    start_v = 3'b000;
    rst_v = 3'b111;
    repeat (2) @(negedge clk);
    nvec++;
    if (cs_n_v[1] !== 1'b1 || busy_v[1] !== 1'b0) begin
      nmis++;
      $display("[TB] FAIL idle after reset: cs_n=%b busy=%b, wanted 1 0", cs_n_v[1], busy_v[1]);
    end
  endtask

  task automatic test_single();
    logic [TB-1:0] rx;
    logic fb, lb;
    int ones;
    logic [3:0] ent;
    run_frame(1, 64'hFEDCBA9876543210, 1'b0, -10, '0, "single", rx, fb, lb, ones);
    @(negedge clk);
    nvec++;
    if (done_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || cs_n_v[1] !== 1'b1) begin
      nmis++;
      $display("[TB] FAIL after done: done=%b busy=%b cs_n=%b, wanted 0 0 1", done_v[1], busy_v[1], cs_n_v[1]);
    end
    for (int sel = 0; sel < 16; sel++) begin
      ent = rx[4*sel +: 4];
      nvec++;
      if (ent !== 4'(sel)) begin
        nmis++;
        $display("[TB] FAIL lut sel=%0d: out got %0d, wanted %0d", sel, ent, sel);
      end
    end
  endtask

  task automatic test_bit_order();
    logic [TB-1:0] rx;
    logic fb, lb;
    int ones;
    run_frame(1, 64'h8000000000000001, 1'b0, -10, '0, "bit_order", rx, fb, lb, ones);
    nvec++;
    if (fb !== 1'b1 || lb !== 1'b1 || ones !== 2) begin
      nmis++;
      $display("[TB] FAIL bit order: first=%b last=%b ones=%0d, wanted 1 1 2", fb, lb, ones);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    logic [TB-1:0] rx;
    logic fb, lb;
    int ones;
    run_frame(1, 64'h0123456789ABCDEF, 1'b0, 50, 64'hFEDCBA9876543210, "ignored_start", rx, fb, lb, ones);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [TB-1:0] rx;
    logic fb, lb;
    int ones;
    run_frame(1, 64'hA5A5_0F0F_3C3C_9669, 1'b1, -10, '0, "b2b_first", rx, fb, lb, ones);
    run_frame(1, 64'h1357_9BDF_2468_ACE0, 1'b0, -10, '0, "b2b_second", rx, fb, lb, ones);
    @(negedge clk);
  endtask

  task automatic test_mid_reset(input int d);
    logic [TB-1:0] rx;
    logic fb, lb;
    int ones;
    int cd;
    cd = d + 1;
    start_v[d] = 1'b1;
    tbl_v[d] = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    start_v[d] = 1'b0;
    repeat (41 * cd) @(negedge clk);
    nvec++;
    if (sclk_v[d] !== 1'b1 || cs_n_v[d] !== 1'b0) begin
      nmis++;
      $display("[TB] FAIL mid_reset[%0d] bit 20 rise: sclk=%b cs_n=%b, wanted 1 0", d, sclk_v[d], cs_n_v[d]);
    end
    rst_v[d] = 1'b0;
    #1;
    nvec++;
    if ({sdo_v[d], sclk_v[d], cs_n_v[d], busy_v[d], done_v[d]} !== 5'b00100) begin
      nmis++;
      $display("[TB] FAIL mid_reset[%0d] forced idle: got %b%b%b%b%b, wanted 00100",
               d, sdo_v[d], sclk_v[d], cs_n_v[d], busy_v[d], done_v[d]);
    end
    @(negedge clk);
    rst_v[d] = 1'b1;
    @(negedge clk);
    run_frame(d, 64'h0F1E_2D3C_4B5A_6978, 1'b0, -10, '0, $sformatf("after_reset_cd%0d", cd), rx, fb, lb, ones);
    @(negedge clk);
  endtask

  initial begin
    start_v = 3'b000;
    rst_v = 3'b000;
    for (int i = 0; i < 3; i++) tbl_v[i] = '0;
    test_reset();
    test_single();
    test_bit_order();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset(0);
    test_mid_reset(1);
    test_mid_reset(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
